// File: rtl/eship_projectile_bank.sv
// Enemy projectile slot bank: loads slots from the finder's activation
// vector, moves live projectiles once per frame, retires them on hit or
// when they leave the screen, and reports per-slot busy flags.
module eship_projectile_bank #(
    parameter int NPE          = 4,
    parameter int SPAWN_DY     = 16,
    parameter int SPEED_Y      = 4,
    parameter int SPEED_X      = 1,
    parameter int AIM_DEADBAND = 8,
    parameter int Y_MAX        = 479,
    parameter int X_MAX        = 639
) (
    input  logic                       frame_clk,
    input  logic                       Reset,
    input  logic [NPE-1:0]             EProjActvt,
    input  logic [9:0]                 ShooterX,
    input  logic [9:0]                 ShooterY,
    input  logic [9:0]                 PlayerX,
    input  logic [NPE-1:0]             EProjHit,
    output logic [NPE-1:0]             EProjEn,
    output logic [NPE*10-1:0]          EProjX,
    output logic [NPE*10-1:0]          EProjY,
    output logic [$clog2(NPE+1)-1:0]   ActiveCount,
    output logic                       ActvtErr
);

    localparam int CW = $clog2(NPE+1);

    localparam logic [10:0]        SPAWN_DY_W = 11'(SPAWN_DY);
    localparam logic [10:0]        DEADBAND_W = 11'(AIM_DEADBAND);
    localparam logic [11:0]        SPEED_Y_W  = 12'(SPEED_Y);
    localparam logic signed [11:0] SPEED_X_S  = 12'(SPEED_X);
    localparam logic [11:0]        Y_MAX_W    = 12'(Y_MAX);
    localparam logic signed [11:0] X_MAX_S    = 12'(X_MAX);

    typedef enum logic {IDLE, FLY} slotState_t;
    typedef enum logic [1:0] {
        DIR_NONE  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_LEFT  = 2'b11
    } xDir_t;

    slotState_t        state     [NPE];
    slotState_t        stateNext [NPE];
    logic [9:0]        posX      [NPE];
    logic [9:0]        posXNext  [NPE];
    // Y carries an extra bit so a spawn computed below the screen is kept
    // intact and retires on the following frame instead of wrapping.
    logic [10:0]       posY      [NPE];
    logic [10:0]       posYNext  [NPE];
    xDir_t             dir       [NPE];
    xDir_t             dirNext   [NPE];
    logic [11:0]       moveY     [NPE];
    logic signed [11:0] moveX    [NPE];
    logic [10:0]       spawnY;
    xDir_t             spawnDir;
    logic              errNext;
    logic [CW-1:0]     countNext;

    // Spawn position and aim direction shared by every slot activated this cycle
    always_comb begin
        spawnY   = {1'b0, ShooterY} + SPAWN_DY_W;
        spawnDir = DIR_NONE;
        if ({1'b0, PlayerX} > {1'b0, ShooterX} + DEADBAND_W)
            spawnDir = DIR_RIGHT;
        else if ({1'b0, PlayerX} + DEADBAND_W < {1'b0, ShooterX})
            spawnDir = DIR_LEFT;
    end

    // Candidate position one frame ahead for each slot
    always_comb begin
        for (int unsigned i = 0; i < NPE; i++) begin
            moveY[i] = {1'b0, posY[i]} + SPEED_Y_W;
            case (dir[i])
                DIR_RIGHT: moveX[i] = $signed({2'b00, posX[i]}) + SPEED_X_S;
                DIR_LEFT:  moveX[i] = $signed({2'b00, posX[i]}) - SPEED_X_S;
                default:   moveX[i] = $signed({2'b00, posX[i]});
            endcase
        end
    end

    // Per-slot next-state logic, sticky error flag and live-slot count
    always_comb begin
        errNext   = ActvtErr;
        countNext = '0;
        for (int unsigned i = 0; i < NPE; i++) begin
            stateNext[i] = state[i];
            posXNext[i]  = posX[i];
            posYNext[i]  = posY[i];
            dirNext[i]   = dir[i];
            case (state[i])
                IDLE: begin
                    if (EProjActvt[i]) begin
                        stateNext[i] = FLY;
                        posXNext[i]  = ShooterX;
                        posYNext[i]  = spawnY;
                        dirNext[i]   = spawnDir;
                    end
                end
                FLY: begin
                    if (EProjActvt[i])
                        errNext = 1'b1;
                    if (EProjHit[i] || (moveY[i] > Y_MAX_W) ||
                        (moveX[i] < 12'sd0) || (moveX[i] > X_MAX_S)) begin
                        stateNext[i] = IDLE;
                    end else begin
                        posXNext[i] = moveX[i][9:0];
                        posYNext[i] = moveY[i][10:0];
                    end
                end
                default: stateNext[i] = IDLE;
            endcase
            if (stateNext[i] == FLY)
                countNext = countNext + CW'(1);
        end
    end

    // Slot registers, error flag and count; reset overrides everything
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            for (int unsigned i = 0; i < NPE; i++) begin
                state[i] <= IDLE;
                posX[i]  <= '0;
                posY[i]  <= '0;
                dir[i]   <= DIR_NONE;
            end
            ActvtErr    <= 1'b0;
            ActiveCount <= '0;
        end else begin
            for (int unsigned i = 0; i < NPE; i++) begin
                state[i] <= stateNext[i];
                posX[i]  <= posXNext[i];
                posY[i]  <= posYNext[i];
                dir[i]   <= dirNext[i];
            end
            ActvtErr    <= errNext;
            ActiveCount <= countNext;
        end
    end

    // Pack registered slot state onto the output buses
    always_comb begin
        for (int unsigned i = 0; i < NPE; i++) begin
            EProjEn[i]         = (state[i] == FLY);
            EProjX[10*i +: 10] = posX[i];
            EProjY[10*i +: 10] = posY[i][9:0];
        end
    end

endmodule

// File: tb/tb_eship_projectile_bank.sv
// Directed bench for eship_projectile_bank: spawn, motion, edge and hit
// retirement, activation errors, full bank and reset behaviour.
module tb_eship_projectile_bank;

    logic        frame_clk;
    logic        Reset;
    logic [3:0]  EProjActvt;
    logic [9:0]  ShooterX;
    logic [9:0]  ShooterY;
    logic [9:0]  PlayerX;
    logic [3:0]  EProjHit;
    logic [3:0]  EProjEn;
    logic [39:0] EProjX;
    logic [39:0] EProjY;
    logic [2:0]  ActiveCount;
    logic        ActvtErr;

    int checks   = 0;
    int failures = 0;

    eship_projectile_bank #(
        .NPE(4), .SPAWN_DY(16), .SPEED_Y(4), .SPEED_X(1),
        .AIM_DEADBAND(8), .Y_MAX(479), .X_MAX(639)
    ) dut (
        .frame_clk(frame_clk), .Reset(Reset), .EProjActvt(EProjActvt),
        .ShooterX(ShooterX), .ShooterY(ShooterY), .PlayerX(PlayerX),
        .EProjHit(EProjHit), .EProjEn(EProjEn), .EProjX(EProjX),
        .EProjY(EProjY), .ActiveCount(ActiveCount), .ActvtErr(ActvtErr)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    function automatic logic [9:0] xOf(input int i);
        return EProjX[10*i +: 10];
    endfunction

    function automatic logic [9:0] yOf(input int i);
        return EProjY[10*i +: 10];
    endfunction

    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [9:0] sx, input logic [9:0] sy,
                         input logic [9:0] px, input logic [3:0] h);
        EProjActvt = a; ShooterX = sx; ShooterY = sy; PlayerX = px; EProjHit = h;
    endtask

    initial begin
        Reset = 1'b1;
        drive(4'b0000, 10'd0, 10'd0, 10'd0, 4'b0000);
        step(); step();
        chk("rst_en", EProjEn, 0);
        chk("rst_cnt", ActiveCount, 0);
        chk("rst_err", ActvtErr, 0);
        chk("rst_x", EProjX, 0);
        chk("rst_y", EProjY, 0);
        Reset = 1'b0;

        // Straight shot: 305 is within the deadband of 300
        drive(4'b0001, 10'd300, 10'd100, 10'd305, 4'b0000);
        step();
        drive(4'b0000, 10'd0, 10'd0, 10'd0, 4'b0000);
        chk("str_en", EProjEn, 4'b0001);
        chk("str_x0", xOf(0), 300);
        chk("str_y0", yOf(0), 116);
        chk("str_cnt", ActiveCount, 1);
        step();
        chk("str_y1", yOf(0), 120);
        chk("str_x1", xOf(0), 300);
        repeat (89) step();
        chk("str_y476", yOf(0), 476);
        chk("str_en476", EProjEn, 4'b0001);
        step();
        chk("str_ret_en", EProjEn, 4'b0000);
        chk("str_ret_y", yOf(0), 476);
        chk("str_ret_x", xOf(0), 300);
        chk("str_ret_cnt", ActiveCount, 0);

        // Aimed right slot1, then slot2 inside the deadband, hit on slot1
        drive(4'b0010, 10'd100, 10'd50, 10'd400, 4'b0000);
        step();
        chk("aim1_x", xOf(1), 100);
        chk("aim1_y", yOf(1), 66);
        drive(4'b0100, 10'd5, 10'd10, 10'd0, 4'b0000);
        step();
        chk("aim1_x1", xOf(1), 101);
        chk("aim1_y1", yOf(1), 70);
        chk("s2_x", xOf(2), 5);
        chk("s2_y", yOf(2), 26);
        drive(4'b0000, 10'd0, 10'd0, 10'd0, 4'b0010);
        step();
        chk("hit1_en", EProjEn, 4'b0100);
        chk("hit1_x", xOf(1), 101);
        chk("hit1_y", yOf(1), 70);
        chk("hit1_cnt", ActiveCount, 1);
        chk("s2_x2", xOf(2), 5);
        chk("s2_y2", yOf(2), 30);
        step();
        chk("idlehit_en", EProjEn, 4'b0100);
        chk("idlehit_x1", xOf(1), 101);
        chk("s2_y3", yOf(2), 34);
        chk("noerr", ActvtErr, 0);
        drive(4'b0100, 10'd200, 10'd200, 10'd200, 4'b0000);
        step();
        chk("busy_err", ActvtErr, 1);
        chk("busy_x2", xOf(2), 5);
        chk("busy_y2", yOf(2), 38);
        chk("busy_en", EProjEn, 4'b0100);
        drive(4'b0100, 10'd200, 10'd200, 10'd200, 4'b0100);
        step();
        chk("hitact_en", EProjEn, 4'b0000);
        chk("hitact_x2", xOf(2), 5);
        chk("hitact_y2", yOf(2), 38);
        chk("hitact_err", ActvtErr, 1);
        drive(4'b0000, 10'd0, 10'd0, 10'd0, 4'b0000);
        step();
        chk("err_sticky", ActvtErr, 1);
        chk("idle_en", EProjEn, 4'b0000);

        // Slot3 aimed right from near the left edge
        drive(4'b1000, 10'd2, 10'd0, 10'd640, 4'b0000);
        step();
        drive(4'b0000, 10'd0, 10'd0, 10'd0, 4'b0000);
        chk("s3_x", xOf(3), 2);
        chk("s3_y", yOf(3), 16);
        step(); step();
        chk("s3_x2", xOf(3), 4);
        chk("s3_y2", yOf(3), 24);
        EProjHit = 4'b1000;
        step();
        EProjHit = 4'b0000;
        chk("s3_ret", EProjEn, 4'b0000);

        // Left edge: X walks down to 0 then retires when nextX = -1
        drive(4'b0001, 10'd20, 10'd0, 10'd0, 4'b0000);
        step();
        drive(4'b0000, 10'd0, 10'd0, 10'd0, 4'b0000);
        chk("left_x", xOf(0), 20);
        repeat (20) step();
        chk("left_x0", xOf(0), 0);
        chk("left_y0", yOf(0), 96);
        chk("left_en", EProjEn, 4'b0001);
        step();
        chk("left_ret_en", EProjEn, 4'b0000);
        chk("left_ret_x", xOf(0), 0);
        chk("left_ret_y", yOf(0), 96);

        // Right edge: retires when nextX = 640
        drive(4'b0010, 10'd636, 10'd0, 10'd700, 4'b0000);
        step();
        drive(4'b0000, 10'd0, 10'd0, 10'd0, 4'b0000);
        repeat (3) step();
        chk("right_x", xOf(1), 639);
        chk("right_y", yOf(1), 28);
        step();
        chk("right_ret_en", EProjEn, 4'b0000);
        chk("right_ret_x", xOf(1), 639);

        // Spawn below the screen: loads, then retires next frame
        drive(4'b0001, 10'd300, 10'd470, 10'd300, 4'b0000);
        step();
        drive(4'b0000, 10'd0, 10'd0, 10'd0, 4'b0000);
        chk("below_en", EProjEn, 4'b0001);
        chk("below_y", yOf(0), 486);
        step();
        chk("below_ret", EProjEn, 4'b0000);
        chk("below_y_hold", yOf(0), 486);

        // Full bank on consecutive frames
        drive(4'b0001, 10'd300, 10'd100, 10'd300, 4'b0000); step();
        drive(4'b0010, 10'd300, 10'd100, 10'd300, 4'b0000); step();
        drive(4'b0100, 10'd300, 10'd100, 10'd300, 4'b0000); step();
        drive(4'b1000, 10'd300, 10'd100, 10'd300, 4'b0000); step();
        drive(4'b0000, 10'd0, 10'd0, 10'd0, 4'b0000);
        chk("full_en", EProjEn, 4'b1111);
        chk("full_cnt", ActiveCount, 4);
        chk("full_y0", yOf(0), 128);
        chk("full_y3", yOf(3), 116);
        EProjHit = 4'b0100;
        step();
        EProjHit = 4'b0000;
        chk("full_ret_en", EProjEn, 4'b1011);
        chk("full_ret_cnt", ActiveCount, 3);
        chk("full_ret_y2", yOf(2), 120);
        drive(4'b0100, 10'd50, 10'd200, 10'd50, 4'b0000);
        step();
        drive(4'b0000, 10'd0, 10'd0, 10'd0, 4'b0000);
        chk("reload_en", EProjEn, 4'b1111);
        chk("reload_x2", xOf(2), 50);
        chk("reload_y2", yOf(2), 216);
        chk("reload_cnt", ActiveCount, 4);
        EProjHit = 4'b1000;
        step();
        EProjHit = 4'b0000;
        chk("three_en", EProjEn, 4'b0111);
        chk("three_err", ActvtErr, 1);

        // Reset mid-flight with three live slots and a pending activation
        Reset = 1'b1;
        EProjActvt = 4'b1000;
        step();
        Reset = 1'b0;
        EProjActvt = 4'b0000;
        chk("mid_rst_en", EProjEn, 4'b0000);
        chk("mid_rst_cnt", ActiveCount, 0);
        chk("mid_rst_err", ActvtErr, 0);
        chk("mid_rst_x", EProjX, 0);
        chk("mid_rst_y", EProjY, 0);

        // Multi-hot activation loads both slots with the same position
        drive(4'b0101, 10'd10, 10'd20, 10'd10, 4'b0000);
        step();
        drive(4'b0000, 10'd0, 10'd0, 10'd0, 4'b0000);
        chk("multi_en", EProjEn, 4'b0101);
        chk("multi_cnt", ActiveCount, 2);
        chk("multi_x0", xOf(0), 10);
        chk("multi_x2", xOf(2), 10);
        chk("multi_y0", yOf(0), 36);
        chk("multi_y2", yOf(2), 36);
        chk("multi_err", ActvtErr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
